salida_control: RTL and testbench

Exit-gate controller for the parking lot: the reading end of the spot registry that the entry controller writes. It holds one plate record per parking spot, accepts the plate typed at the exit keypad, looks it up, and waits for the payment button. It then drives the exit barrier motor open/close and releases the spot, keeping the occupancy count used by the entry side to report "PARQUEADERO OCUPADO".

---
 rtl/parking_pkg.sv | 26 ++
 rtl/registro_placas.sv | 68 ++++++
 rtl/salida_control.sv | 137 +++++++++++++
 tb/tb_salida_control.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants for the parking-lot gate controllers
package parking_pkg;

  localparam int NUM_SPOTS_DEF = 6;

  localparam logic [3:0] MSG_BIENVENIDO = 4'b0000;
  localparam logic [3:0] MSG_PLACA      = 4'b0010;
  localparam logic [3:0] MSG_GRACIAS    = 4'b0111;
  localparam logic [3:0] MSG_CERRANDO   = 4'b1110;
  localparam logic [3:0] MSG_NOENC      = 4'b1101;
  localparam logic [3:0] MSG_PAGAR      = 4'b1111;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PLATE      = 3'd1;
  localparam logic [2:0] ST_LOOKUP     = 3'd2;
  localparam logic [2:0] ST_PAY        = 3'd3;
  localparam logic [2:0] ST_OPEN       = 3'd4;
  localparam logic [2:0] ST_WAIT_CLEAR = 3'd5;
  localparam logic [2:0] ST_CLOSE      = 3'd6;
  localparam logic [2:0] ST_NOTFOUND   = 3'd7;

  localparam logic [1:0] MOTOR_OFF   = 2'b00;
  localparam logic [1:0] MOTOR_OPEN  = 2'b01;
  localparam logic [1:0] MOTOR_CLOSE = 2'b10;

endpackage

// File: rtl/registro_placas.sv
// rtl/registro_placas.sv - per-spot plate registry with write, release and compare ports
module registro_placas
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = NUM_SPOTS_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [2:0]                     wr_spot,
  input  logic [23:0]                    wr_placa,
  input  logic                           rel_en,
  input  logic [2:0]                     rel_spot,
  input  logic [2:0]                     cmp_idx,
  input  logic [23:0]                    cmp_placa,
  output logic                           cmp_hit,
  output logic [$clog2(NUM_SPOTS+1)-1:0] ocupados
);

  localparam int OCW = $clog2(NUM_SPOTS + 1);
  localparam logic [OCW-1:0] FULL = OCW'(NUM_SPOTS);

  logic [NUM_SPOTS:1] valid;
  logic [23:0]        placas [1:NUM_SPOTS];
  logic               wr_ok, wr_was_valid, rel_ok, inc, dec;

  // Spot numbers outside 1..NUM_SPOTS simply never match any record.
  always_comb begin
    wr_ok        = 1'b0;
    wr_was_valid = 1'b0;
    rel_ok       = 1'b0;
    cmp_hit      = 1'b0;
    for (int i = 1; i <= NUM_SPOTS; i++) begin
      if (wr_spot == 3'(i)) begin
        wr_ok        = wr_en;
        wr_was_valid = valid[i];
      end
      if (rel_spot == 3'(i)) rel_ok = rel_en && valid[i];
      if (cmp_idx == 3'(i) && valid[i] && placas[i] == cmp_placa) cmp_hit = 1'b1;
    end
  end

  assign inc = wr_ok && !wr_was_valid;
  // A write landing on the spot being released keeps it occupied.
  assign dec = rel_ok && !(wr_ok && wr_spot == rel_spot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= '0;
      ocupados <= '0;
      for (int i = 1; i <= NUM_SPOTS; i++) placas[i] <= '0;
    end else begin
      for (int i = 1; i <= NUM_SPOTS; i++) begin
        if (wr_en && wr_spot == 3'(i)) begin
          valid[i]  <= 1'b1;
          placas[i] <= wr_placa;
        end else if (rel_en && rel_spot == 3'(i)) begin
          valid[i] <= 1'b0;
        end
      end
      if (inc && !dec && ocupados != FULL)
        ocupados <= ocupados + OCW'(1);
      else if (dec && !inc && ocupados != '0)
        ocupados <= ocupados - OCW'(1);
    end
  end

endmodule

// File: rtl/salida_control.sv
// rtl/salida_control.sv - exit-gate FSM: plate lookup, payment, barrier motor and spot release
module salida_control
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS   = NUM_SPOTS_DEF,
  parameter int MOTOR_TICKS = 3,
  parameter int ERR_TICKS   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic                           s_n,
  input  logic                           placa_valid,
  input  logic [23:0]                    placa,
  input  logic                           pagado_n,
  input  logic                           wr_en,
  input  logic [2:0]                     wr_spot,
  input  logic [23:0]                    wr_placa,
  output logic [1:0]                     m,
  output logic [3:0]                     message,
  output logic [$clog2(NUM_SPOTS+1)-1:0] ocupados,
  output logic                           lleno,
  output logic                           rel_valid,
  output logic [2:0]                     rel_spot
);

  localparam int OCW = $clog2(NUM_SPOTS + 1);
  localparam logic [7:0] MOT_LAST = 8'(MOTOR_TICKS - 1);
  localparam logic [7:0] ERR_LAST = 8'(ERR_TICKS - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_SPOTS);

  logic [2:0]  state, idx, spot;
  logic [23:0] placa_q;
  logic [7:0]  timer;
  logic        rel_en, cmp_hit;

  assign rel_en = (state == ST_PAY) && !pagado_n;
  assign lleno  = (ocupados == OCW'(NUM_SPOTS));

  registro_placas #(.NUM_SPOTS(NUM_SPOTS)) u_registro (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_spot   (wr_spot),
    .wr_placa  (wr_placa),
    .rel_en    (rel_en),
    .rel_spot  (spot),
    .cmp_idx   (idx),
    .cmp_placa (placa_q),
    .cmp_hit   (cmp_hit),
    .ocupados  (ocupados)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      spot      <= '0;
      placa_q   <= '0;
      timer     <= '0;
      m         <= MOTOR_OFF;
      message   <= MSG_BIENVENIDO;
      rel_valid <= 1'b0;
      rel_spot  <= '0;
    end else begin
      rel_valid <= 1'b0;
      case (state)
        ST_IDLE: if (!s_n) begin
          state   <= ST_PLATE;
          message <= MSG_PLACA;
        end
        ST_PLATE: if (placa_valid) begin
          placa_q <= placa;
          idx     <= 3'd1;
          state   <= ST_LOOKUP;
        end else if (s_n) begin
          state   <= ST_IDLE;
          message <= MSG_BIENVENIDO;
        end
        // One record compared per clock, lowest spot first.
        ST_LOOKUP: if (cmp_hit) begin
          spot    <= idx;
          state   <= ST_PAY;
          message <= MSG_PAGAR;
        end else if (idx == LAST_IDX) begin
          state   <= ST_NOTFOUND;
          message <= MSG_NOENC;
          timer   <= '0;
        end else begin
          idx <= idx + 3'd1;
        end
        ST_NOTFOUND: if (tick) begin
          if (timer == ERR_LAST) begin
            timer   <= '0;
            state   <= ST_PLATE;
            message <= MSG_PLACA;
          end else timer <= timer + 8'd1;
        end
        ST_PAY: if (!pagado_n) begin
          rel_valid <= 1'b1;
          rel_spot  <= spot;
          state     <= ST_OPEN;
          message   <= MSG_GRACIAS;
          m         <= MOTOR_OPEN;
          timer     <= '0;
        end
        ST_OPEN: if (tick) begin
          if (timer == MOT_LAST) begin
            timer <= '0;
            m     <= MOTOR_OFF;
            state <= ST_WAIT_CLEAR;
          end else timer <= timer + 8'd1;
        end
        ST_WAIT_CLEAR: if (s_n) begin
          state   <= ST_CLOSE;
          message <= MSG_CERRANDO;
          m       <= MOTOR_CLOSE;
          timer   <= '0;
        end
        ST_CLOSE: if (tick) begin
          if (timer == MOT_LAST) begin
            timer   <= '0;
            m       <= MOTOR_OFF;
            state   <= ST_IDLE;
            message <= MSG_BIENVENIDO;
          end else timer <= timer + 8'd1;
        end
        default: begin
          state   <= ST_IDLE;
          m       <= MOTOR_OFF;
          message <= MSG_BIENVENIDO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_salida_control.sv
// tb/tb_salida_control.sv - randomized self-checking bench for salida_control
module tb_salida_control;
  import parking_pkg::*;

  localparam int NS = 6;
  localparam int MT = 3;
  localparam int ET = 2;

  logic        clk = 1'b0;
  logic        reset_n, tick, s_n, placa_valid, pagado_n, wr_en;
  logic [23:0] placa, wr_placa;
  logic [2:0]  wr_spot, rel_spot;
  logic [1:0]  m;
  logic [3:0]  message;
  logic [2:0]  ocupados;
  logic        lleno, rel_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mv [1:NS];
  logic [23:0] mp [1:NS];
  logic [23:0] pool [5];

  always #10 clk = ~clk;

  salida_control #(.NUM_SPOTS(NS), .MOTOR_TICKS(MT), .ERR_TICKS(ET)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .s_n         (s_n),
    .placa_valid (placa_valid),
    .placa       (placa),
    .pagado_n    (pagado_n),
    .wr_en       (wr_en),
    .wr_spot     (wr_spot),
    .wr_placa    (wr_placa),
    .m           (m),
    .message     (message),
    .ocupados    (ocupados),
    .lleno       (lleno),
    .rel_valid   (rel_valid),
    .rel_spot    (rel_spot)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = ($urandom_range(0, 2) == 0);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 1; i <= NS; i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic int model_find(input logic [23:0] p);
    for (int i = 1; i <= NS; i++) if (mv[i] && mp[i] == p) return i;
    return 0;
  endfunction

  task automatic check_count(input string tag);
    check_eq({tag, "_ocupados"}, 32'(ocupados), 32'(model_count()));
    check_eq({tag, "_lleno"}, 32'(lleno), 32'(model_count() == NS));
  endtask

  task automatic write_rec(input int s, input logic [23:0] p);
    wr_en = 1'b1; wr_spot = 3'(s); wr_placa = p;
    step();
    wr_en = 1'b0;
    if (s >= 1 && s <= NS) begin mv[s] = 1'b1; mp[s] = p; end
    check_count("write");
  endtask

  task automatic count_ticks(input logic [1:0] m_exp, input logic [3:0] msg_exp, inout int cnt);
    int guard = 0;
    while (m == m_exp && message == msg_exp && guard < 200) begin
      if (tick) cnt++;
      step();
      guard++;
    end
    check_eq("timer_bound", 32'(guard < 200), 32'(1));
  endtask

  task automatic do_exit(input logic [23:0] p, input bit collide, input logic [23:0] newp);
    int k, n, cnt;
    k = model_find(p);
    s_n = 1'b0;
    step();
    check_eq("msg_plate", 32'(message), 32'(MSG_PLACA));
    placa = p; placa_valid = 1'b1;
    step();
    placa_valid = 1'b0;
    n = 0;
    while (message == MSG_PLACA && n < 20) begin step(); n++; end
    check_eq("lookup_cycles", 32'(n), 32'(k == 0 ? NS : k));
    if (k != 0) begin
      check_eq("msg_pay", 32'(message), 32'(MSG_PAGAR));
      repeat ($urandom_range(0, 3)) begin
        placa_valid = 1'(($urandom_range(0, 1)));
        step();
        check_eq("pay_hold", 32'(message), 32'(MSG_PAGAR));
      end
      placa_valid = 1'b0;
      pagado_n = 1'b0;
      if (collide) begin wr_en = 1'b1; wr_spot = 3'(k); wr_placa = newp; end
      step();
      pagado_n = 1'b1; wr_en = 1'b0;
      if (collide) mp[k] = newp; else mv[k] = 1'b0;
      check_eq("rel_valid", 32'(rel_valid), 32'(1));
      check_eq("rel_spot", 32'(rel_spot), 32'(k));
      check_eq("m_open", 32'(m), 32'(MOTOR_OPEN));
      check_eq("msg_thanks", 32'(message), 32'(MSG_GRACIAS));
      check_count("release");
      cnt = int'(tick);
      step();
      check_eq("rel_pulse_end", 32'(rel_valid), 32'(0));
      count_ticks(MOTOR_OPEN, MSG_GRACIAS, cnt);
      check_eq("open_ticks", 32'(cnt), 32'(MT));
      check_eq("m_wait", 32'(m), 32'(MOTOR_OFF));
      check_eq("msg_wait", 32'(message), 32'(MSG_GRACIAS));
      repeat ($urandom_range(1, 4)) begin
        pagado_n = 1'(($urandom_range(0, 1)));
        placa_valid = 1'(($urandom_range(0, 1)));
        step();
        check_eq("wait_no_rel", 32'(rel_valid), 32'(0));
        check_eq("wait_m_off", 32'(m), 32'(MOTOR_OFF));
      end
      pagado_n = 1'b1; placa_valid = 1'b0;
      check_count("wait");
      s_n = 1'b1;
      step();
      check_eq("m_close", 32'(m), 32'(MOTOR_CLOSE));
      check_eq("msg_closing", 32'(message), 32'(MSG_CERRANDO));
      cnt = 0;
      count_ticks(MOTOR_CLOSE, MSG_CERRANDO, cnt);
      check_eq("close_ticks", 32'(cnt), 32'(MT));
      check_eq("m_idle", 32'(m), 32'(MOTOR_OFF));
      check_eq("msg_idle", 32'(message), 32'(MSG_BIENVENIDO));
    end else begin
      check_eq("msg_notfound", 32'(message), 32'(MSG_NOENC));
      check_count("miss");
      cnt = 0;
      count_ticks(MOTOR_OFF, MSG_NOENC, cnt);
      check_eq("err_ticks", 32'(cnt), 32'(ET));
      check_eq("msg_retry", 32'(message), 32'(MSG_PLACA));
      s_n = 1'b1;
      step();
      check_eq("msg_leave", 32'(message), 32'(MSG_BIENVENIDO));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pool[0] = 24'h111111; pool[1] = 24'h222222; pool[2] = 24'h333333;
    pool[3] = 24'h454545; pool[4] = 24'h777777;
    for (int i = 1; i <= NS; i++) begin mv[i] = 1'b0; mp[i] = '0; end
    reset_n = 1'b0; tick = 1'b0; s_n = 1'b1; placa_valid = 1'b0; placa = '0;
    pagado_n = 1'b1; wr_en = 1'b0; wr_spot = '0; wr_placa = '0;
    step(); step();
    check_eq("rst_message", 32'(message), 32'(MSG_BIENVENIDO));
    check_eq("rst_m", 32'(m), 32'(MOTOR_OFF));
    check_eq("rst_rel_valid", 32'(rel_valid), 32'(0));
    check_eq("rst_rel_spot", 32'(rel_spot), 32'(0));
    check_count("rst");
    reset_n = 1'b1;
    step();

    write_rec(3, 24'h123456);
    do_exit(24'h123456, 1'b0, '0);

    write_rec(1, 24'h100001); write_rec(2, 24'h111111); write_rec(3, 24'h333333);
    write_rec(4, 24'h444444); write_rec(5, 24'h111111); write_rec(6, 24'h666666);
    do_exit(24'h999999, 1'b0, '0);
    do_exit(24'h111111, 1'b0, '0);
    do_exit(24'h111111, 1'b0, '0);

    do_exit(24'h444444, 1'b1, 24'h454545);
    write_rec(0, 24'hDEAD00);
    write_rec(7, 24'hDEAD07);
    do_exit(24'h454545, 1'b0, '0);

    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(1, 3)) write_rec($urandom_range(0, 7), pool[$urandom_range(0, 4)]);
      do_exit(pool[$urandom_range(0, 4)], 1'($urandom_range(0, 3) == 0), pool[$urandom_range(0, 4)]);
    end

    s_n = 1'b0;
    step();
    check_eq("leave_plate", 32'(message), 32'(MSG_PLACA));
    s_n = 1'b1;
    step();
    check_eq("leave_idle", 32'(message), 32'(MSG_BIENVENIDO));
    placa = 24'h111111; placa_valid = 1'b1;
    step();
    placa_valid = 1'b0;
    step();
    check_eq("late_placa_ignored", 32'(message), 32'(MSG_BIENVENIDO));

    write_rec(1, 24'hABCDEF);
    s_n = 1'b0;
    step();
    placa = 24'hABCDEF; placa_valid = 1'b1;
    step();
    placa_valid = 1'b0;
    repeat (NS + 2) if (message != MSG_PAGAR) step();
    pagado_n = 1'b0;
    step();
    pagado_n = 1'b1;
    check_eq("rst_test_open", 32'(m), 32'(MOTOR_OPEN));
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_m", 32'(m), 32'(MOTOR_OFF));
    for (int i = 1; i <= NS; i++) mv[i] = 1'b0;
    check_count("async_rst");
    check_eq("async_rst_msg", 32'(message), 32'(MSG_BIENVENIDO));
    step();
    reset_n = 1'b1;
    step();
    check_eq("post_rst_to_plate", 32'(message), 32'(MSG_PLACA));
    s_n = 1'b1;
    step();
    do_exit(24'hABCDEF, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
